// File: rtl/wb_snoop_pkg.sv
// Shared types for the Wishbone snoop broadcaster: queue entry,
// issue FSM states and the per-core mask helper.
package wb_snoop_pkg;

    localparam int SRC_MAX_W = 8;
    localparam int MAX_CORES = 1 << SRC_MAX_W;

    // line_adr keeps the byte address with the in-line bits zeroed
    typedef struct packed {
        logic [31:0]          line_adr;
        logic [SRC_MAX_W-1:0] src;
        logic                 dbg;
    } snoop_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } snoop_state_e;

    function automatic logic [MAX_CORES-1:0] onehot_mask(
        input logic [SRC_MAX_W-1:0] src,
        input int unsigned          n
    );
        logic [MAX_CORES-1:0] m;
        m = '0;
        if (32'(src) < n) begin
            m[src] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_snoop_bcast_fifo.sv
// snoop_fifo: synchronous FIFO of snoop_entry_t (power-of-2 depth).
// Ports: clk, rst (sync, high), push/din, pop/head, tail, count, empty.
module snoop_fifo
    import wb_snoop_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  snoop_entry_t             din,
    input  logic                     pop,
    output snoop_entry_t             head,
    output snoop_entry_t             tail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    snoop_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign tail  = mem[wr_ptr - 1'b1];
    assign empty = (count == '0);

endmodule

// File: rtl/wb_snoop_bcast.sv
// wb_snoop_bcast: queues acked RAM write beats as line addresses and
// broadcasts them, paced, as snoop pulses to every core but the writer.
// Ports: wb_clk_i/wb_rst_i; mon_* Wishbone RAM-slave monitor inputs;
// snoop_adr_o/snoop_en_o snoop outputs; snoop_stall_o almost-full;
// snoop_ovf_o sticky drop flag, cleared by snoop_clr_i.
// Macro WB_SNOOP_COALESCE_EN: skip pushes equal to the queue tail.
module wb_snoop_bcast
    import wb_snoop_pkg::*;
#(
    parameter int NUM_CORES  = 1,
    parameter int LINE_BITS  = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int SNOOP_GAP  = 1,
    parameter int SRC_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [31:0]          mon_adr_i,
    input  logic                 mon_we_i,
    input  logic                 mon_cyc_i,
    input  logic                 mon_stb_i,
    input  logic                 mon_ack_i,
    input  logic [SRC_W-1:0]     mon_src_i,
    input  logic                 mon_dbg_i,
    output logic [31:0]          snoop_adr_o,
    output logic [NUM_CORES-1:0] snoop_en_o,
    output logic                 snoop_stall_o,
    output logic                 snoop_ovf_o,
    input  logic                 snoop_clr_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

`ifdef WB_SNOOP_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    snoop_entry_t   new_entry;
    snoop_entry_t   head;
    snoop_entry_t   tail;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_n;
    logic           empty;
    logic           beat;
    logic           same;
    logic           push_ok;
    logic           drop;
    logic           pop;

    snoop_state_e   state;
    snoop_state_e   state_n;
    logic [3:0]     gap_q;
    logic [3:0]     gap_n;
    logic [31:0]    adr_n;
    logic [NUM_CORES-1:0] en_n;
    logic [NUM_CORES-1:0] head_mask;

    assign beat = mon_cyc_i & mon_stb_i & mon_we_i & mon_ack_i;

    assign new_entry.line_adr = mon_adr_i & ~((32'd1 << LINE_BITS) - 32'd1);
    assign new_entry.src      = SRC_MAX_W'(mon_src_i);
    assign new_entry.dbg      = mon_dbg_i;

    assign same    = COALESCE & ~empty & (tail == new_entry);
    // a pop at this edge frees a slot for the incoming beat
    assign push_ok = beat & ~same & ((count < CW'(FIFO_DEPTH)) | pop);
    assign drop    = beat & ~same & ~push_ok;
    assign count_n = count + CW'(push_ok) - CW'(pop);

    snoop_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push_ok),
        .din   (new_entry),
        .pop   (pop),
        .head  (head),
        .tail  (tail),
        .count (count),
        .empty (empty)
    );

    assign head_mask = head.dbg
        ? {NUM_CORES{1'b1}}
        : ~NUM_CORES'(onehot_mask(head.src, NUM_CORES));

    always_comb begin
        state_n = state;
        gap_n   = gap_q;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (SNOOP_GAP == 0) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    state_n = GAP;
                    gap_n   = 4'(SNOOP_GAP);
                end
            end
            GAP: begin
                if (gap_q <= 4'd1) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gap_n = gap_q - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        en_n  = pop ? head_mask : '0;
        adr_n = pop ? head.line_adr : snoop_adr_o;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            gap_q         <= '0;
            snoop_adr_o   <= '0;
            snoop_en_o    <= '0;
            snoop_stall_o <= 1'b0;
            snoop_ovf_o   <= 1'b0;
        end else begin
            state         <= state_n;
            gap_q         <= gap_n;
            snoop_adr_o   <= adr_n;
            snoop_en_o    <= en_n;
            snoop_stall_o <= (count_n >= CW'(FIFO_DEPTH - 1));
            if (drop) begin
                snoop_ovf_o <= 1'b1;
            end else if (snoop_clr_i) begin
                snoop_ovf_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_snoop_bcast.sv
// Bench for wb_snoop_bcast: two instances (gap 2 and gap 15, 4 cores)
// driven from shared stimulus; table vectors plus multi-cycle sequences.
module tb_wb_snoop_bcast;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic        we, cyc, stb, ack;
    logic [1:0]  src;
    logic        dbg;
    logic        clr;

    logic [31:0] adr_a, adr_b;
    logic [3:0]  en_a, en_b;
    logic        stall_a, stall_b, ovf_a, ovf_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] padr [32];
    logic [3:0]  pen  [32];
    int          pcyc [32];
    int          np;

    always #5 clk = ~clk;

    wb_snoop_bcast #(
        .NUM_CORES (4), .LINE_BITS (5), .FIFO_DEPTH (8), .SNOOP_GAP (2)
    ) dut_a (
        .wb_clk_i (clk), .wb_rst_i (rst),
        .mon_adr_i (adr), .mon_we_i (we), .mon_cyc_i (cyc),
        .mon_stb_i (stb), .mon_ack_i (ack), .mon_src_i (src),
        .mon_dbg_i (dbg), .snoop_adr_o (adr_a), .snoop_en_o (en_a),
        .snoop_stall_o (stall_a), .snoop_ovf_o (ovf_a),
        .snoop_clr_i (clr)
    );

    wb_snoop_bcast #(
        .NUM_CORES (4), .LINE_BITS (5), .FIFO_DEPTH (8), .SNOOP_GAP (15)
    ) dut_b (
        .wb_clk_i (clk), .wb_rst_i (rst),
        .mon_adr_i (adr), .mon_we_i (we), .mon_cyc_i (cyc),
        .mon_stb_i (stb), .mon_ack_i (ack), .mon_src_i (src),
        .mon_dbg_i (dbg), .snoop_adr_o (adr_b), .snoop_en_o (en_b),
        .snoop_stall_o (stall_b), .snoop_ovf_o (ovf_b),
        .snoop_clr_i (clr)
    );

    typedef struct {
        logic [31:0] adr;
        logic [1:0]  src;
        logic        dbg;
        logic [31:0] exp_adr;
        logic [3:0]  exp_en;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_on(input logic [31:0] a, input logic [1:0] s,
                           input logic d);
        adr = a; src = s; dbg = d;
        we = 1'b1; cyc = 1'b1; stb = 1'b1; ack = 1'b1;
    endtask

    task automatic beat_off();
        we = 1'b0; cyc = 1'b0; stb = 1'b0; ack = 1'b0;
    endtask

    task automatic do_reset();
        beat_off();
        clr = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        np = 0;
    endtask

    task automatic rec(input logic [3:0] en, input logic [31:0] a,
                       input int c);
        if (en != 4'b0000) begin
            if (np < 32) begin
                padr[np] = a;
                pen[np]  = en;
                pcyc[np] = c;
            end
            np++;
        end
    endtask

    initial begin
        int exp_n;

        vecs[0] = '{32'h0000_1234, 2'd2, 1'b0, 32'h0000_1220, 4'b1011};
        vecs[1] = '{32'h0000_0040, 2'd3, 1'b1, 32'h0000_0040, 4'b1111};
        vecs[2] = '{32'hFFFF_FFFF, 2'd0, 1'b0, 32'hFFFF_FFE0, 4'b1110};
        vecs[3] = '{32'h0000_0020, 2'd3, 1'b0, 32'h0000_0020, 4'b0111};
        vecs[4] = '{32'h0000_001F, 2'd1, 1'b0, 32'h0000_0000, 4'b1101};

        adr = '0; src = '0; dbg = 1'b0;
        do_reset();

        chk("rst_en", 32'(en_a), 32'h0);
        chk("rst_adr", adr_a, 32'h0);
        chk("rst_stall", 32'(stall_a), 32'h0);
        chk("rst_ovf", 32'(ovf_a), 32'h0);
        chk("rst_en_b", 32'(en_b), 32'h0);

        // single-beat vectors: latency, mask, alignment, 1-cycle pulse
        for (int i = 0; i < 5; i++) begin
            beat_on(vecs[i].adr, vecs[i].src, vecs[i].dbg);
            tick();
            beat_off();
            chk($sformatf("v%0d_pre_en", i), 32'(en_a), 32'h0);
            tick();
            chk($sformatf("v%0d_en", i), 32'(en_a), 32'(vecs[i].exp_en));
            chk($sformatf("v%0d_adr", i), adr_a, vecs[i].exp_adr);
            tick();
            chk($sformatf("v%0d_post_en", i), 32'(en_a), 32'h0);
            chk($sformatf("v%0d_hold_adr", i), adr_a, vecs[i].exp_adr);
            repeat (4) tick();
        end

        // pacing with gap 2: three beats -> pulses 3 cycles apart
        do_reset();
        for (int c = 0; c < 30; c++) begin
            if (c == 0) beat_on(32'h200, 2'd0, 1'b0);
            else if (c == 1) beat_on(32'h300, 2'd1, 1'b0);
            else if (c == 2) beat_on(32'h400, 2'd3, 1'b0);
            else beat_off();
            tick();
            rec(en_a, adr_a, c);
        end
        chk("pace_n", 32'(np), 32'd3);
        if (np >= 3) begin
            chk("pace_d1", 32'(pcyc[1] - pcyc[0]), 32'd3);
            chk("pace_d2", 32'(pcyc[2] - pcyc[1]), 32'd3);
            chk("pace_a0", padr[0], 32'h200);
            chk("pace_a1", padr[1], 32'h300);
            chk("pace_a2", padr[2], 32'h400);
            chk("pace_e0", 32'(pen[0]), 32'h0000_000E);
            chk("pace_e2", 32'(pen[2]), 32'h0000_0007);
        end

        // overflow on gap-15 instance: 10 writes, 9 accepted, 1 dropped
        do_reset();
        for (int c = 0; c < 10; c++) begin
            beat_on(32'(c) * 32'h20, 2'd1, 1'b0);
            clr = (c == 9);
            tick();
            rec(en_b, adr_b, c);
            if (c == 6) chk("stall_at6", 32'(stall_b), 32'h0);
            if (c == 7) chk("stall_at7", 32'(stall_b), 32'h1);
            if (c == 8) chk("ovf_before_drop", 32'(ovf_b), 32'h0);
        end
        beat_off();
        clr = 1'b0;
        chk("ovf_set_wins", 32'(ovf_b), 32'h1);
        for (int c = 10; c < 200; c++) begin
            tick();
            rec(en_b, adr_b, c);
        end
        chk("ovf_drain_n", 32'(np), 32'd9);
        for (int k = 0; k < 9 && k < np; k++) begin
            chk($sformatf("ovf_adr%0d", k), padr[k], 32'(k) * 32'h20);
            chk($sformatf("ovf_en%0d", k), 32'(pen[k]), 32'h0000_000D);
        end
        chk("ovf_sticky", 32'(ovf_b), 32'h1);
        chk("stall_drained", 32'(stall_b), 32'h0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf_clr", 32'(ovf_b), 32'h0);

        // 8-beat burst behind a busy issue slot (gap-15 instance)
`ifdef WB_SNOOP_COALESCE_EN
        exp_n = 2;
`else
        exp_n = 9;
`endif
        do_reset();
        for (int c = 0; c < 170; c++) begin
            if (c == 0) beat_on(32'h900, 2'd1, 1'b0);
            else if (c < 9) beat_on(32'h100 + 32'(c - 1) * 32'h4, 2'd0, 1'b0);
            else beat_off();
            tick();
            rec(en_b, adr_b, c);
        end
        chk("burst_n", 32'(np), 32'(exp_n));
        if (np >= 1) chk("burst_a0", padr[0], 32'h900);
        for (int k = 1; k < exp_n && k < np; k++) begin
            chk($sformatf("burst_adr%0d", k), padr[k], 32'h100);
            chk($sformatf("burst_en%0d", k), 32'(pen[k]), 32'h0000_000E);
        end

        // reset with 5 entries queued on gap-2 instance
        do_reset();
        for (int c = 0; c < 7; c++) begin
            beat_on(32'h1000 + 32'(c) * 32'h20, 2'd2, 1'b0);
            tick();
        end
        beat_off();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_en", 32'(en_a), 32'h0);
        chk("mid_rst_adr", adr_a, 32'h0);
        chk("mid_rst_stall", 32'(stall_a), 32'h0);
        chk("mid_rst_ovf", 32'(ovf_a), 32'h0);
        np = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            rec(en_a, adr_a, c);
        end
        chk("mid_rst_no_pulse", 32'(np), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
